cla_pipe_adder: RTL and testbench
=================================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter GROUP, default 4, carry-lookahead group width; WIDTH SHALL be an integer multiple of GROUP, 1 <= GROUP <= 8.
REQ-003 Derived NG = WIDTH/GROUP = pipeline depth in stages (default 4).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, add mode only.
REQ-011 sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored).
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Beat accepted when in_valid && in_ready; result emitted when out_valid && out_ready.
REQ-018 Stage k (0..NG-1) SHALL compute group k (bits k*GROUP+GROUP-1 .. k*GROUP) with full lookahead inside the group: P=a^b', G=a&b', carries from G|P&c, sum=P^C.
REQ-019 b' = sub ? ~b : b; carry into stage 0 = sub ? 1 : cin; carry into stage k>0 = registered group carry-out of stage k-1 for the same beat.
REQ-020 Unprocessed upper operand bits and completed lower sum bits SHALL travel with the beat through stage registers, with a valid bit per stage.
REQ-021 Latency: result of a beat accepted at edge N is on sum/cout/ovf with out_valid=1 after edge N+NG, if no stall.
REQ-022 Throughput: one beat per cycle while out_ready=1.
REQ-023 Stall: in_ready = !(out_valid && !out_ready); when in_ready=0 all stage registers hold; outputs stable until accepted.
REQ-024 Bubbles advance when not stalled; no beat is dropped, duplicated or reordered.
REQ-025 ovf = carry into MSB XOR carry out of MSB.
REQ-026 in_valid with in_ready=0: beat not captured; a, b, cin, sub ignored.
REQ-027 Simultaneous output accept and input accept in the same cycle SHALL both occur (full pipe, no bubble).

Reset
REQ-028 rst=1 SHALL asynchronously clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 while rst=1 and in the first cycle after release.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result emitted for them after release.

Configuration
REQ-030 Macro CLA_SAT_EN defined: when ovf=1, sum SHALL be clamped to signed max (0111..1) if the true result is positive, signed min (1000..0) if negative; ovf still reports 1; cout unchanged; no latency change.
REQ-031 CLA_SAT_EN undefined: sum is the wrapped WIDTH-bit result; no saturation logic present.

Verification (WIDTH=16, GROUP=4)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1 (CLA_SAT_EN: sum=0x7FFF, ovf=1).
REQ-034 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1 (CLA_SAT_EN: 0x8000).
REQ-035 Five back-to-back beats (1+1, 2+2, 3+3, 4+4, 5+5), out_ready low 2 cycles once first result appears -> in_ready=0 during stall, outputs held, results 2,4,6,8,10 in order.
REQ-036 Beats in flight, rst pulsed 1 cycle -> out_valid=0 immediately, no stale result after release; fresh beat 0x1234+0x1111 -> 0x2345 after 4 cycles.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, valid/ready handshake.
// Define CLA_SAT_EN to clamp overflowed results to the signed max/min instead of wrapping.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    logic             in_v_q;
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_bp_q;
    logic             in_c_q;
    logic             adv;

    // The whole pipe moves as one; only a held result at the tail can stop it.
    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;

    // Operand capture: B is already conditioned for subtraction, carry-in forced to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_q  <= 1'b0;
            in_a_q  <= '0;
            in_bp_q <= '0;
            in_c_q  <= 1'b0;
        end else if (adv) begin
            in_v_q  <= in_valid;
            in_a_q  <= a;
            in_bp_q <= sub ? ~b : b;
            in_c_q  <= sub | cin;
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_st
        localparam int IW = WIDTH - gi * GROUP;
        localparam int LO = gi * GROUP;

        logic [IW-1:0]    a_in;
        logic [IW-1:0]    bp_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] grp_sum;
        logic [GROUP:0]   c;
        logic             acc;
        logic             pp;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_res;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        if (gi == 0) begin : g_src
            assign a_in  = in_a_q;
            assign bp_in = in_bp_q;
            assign c_in  = in_c_q;
            assign v_in  = in_v_q;
            assign s_in  = '0;
        end else begin : g_chain
            assign a_in  = g_st[gi-1].g_mid.a_q;
            assign bp_in = g_st[gi-1].g_mid.bp_q;
            assign c_in  = g_st[gi-1].c_q;
            assign v_in  = g_st[gi-1].v_q;
            assign s_in  = g_st[gi-1].s_q;
        end

        assign p = a_in[GROUP-1:0] ^ bp_in[GROUP-1:0];
        assign g = a_in[GROUP-1:0] & bp_in[GROUP-1:0];

        // Flat lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
        always_comb begin
            c    = '0;
            acc  = 1'b0;
            pp   = 1'b0;
            c[0] = c_in;
            for (int i = 0; i < GROUP; i++) begin
                acc = g[i];
                pp  = p[i];
                for (int j = i - 1; j >= 0; j--) begin
                    acc = acc | (pp & g[j]);
                    pp  = pp & p[j];
                end
                c[i+1] = acc | (pp & c_in);
            end
        end

        assign grp_sum = p ^ c[GROUP-1:0];
        // Bits above the finished groups are always zero, so OR-ing drops the group in place.
        assign s_d     = s_in | (WIDTH'(grp_sum) << LO);

        if (gi < NG - 1) begin : g_mid
            logic [IW-GROUP-1:0] a_q;
            logic [IW-GROUP-1:0] bp_q;

            assign s_res = s_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    bp_q <= '0;
                end else if (adv) begin
                    a_q  <= a_in[IW-1:GROUP];
                    bp_q <= bp_in[IW-1:GROUP];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = c[GROUP] ^ c[GROUP-1];
`ifdef CLA_SAT_EN
            // On overflow both addends share a sign, and that sign is the true result's sign.
            assign s_res = !ovf_d ? s_d :
                           (a_in[GROUP-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}});
`else
            assign s_res = s_d;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= c[GROUP];
                s_q <= s_res;
            end
        end
    end

    assign out_valid = g_st[NG-1].v_q;
    assign sum       = g_st[NG-1].s_q;
    assign cout      = g_st[NG-1].c_q;
    assign ovf       = g_st[NG-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=16, GROUP=4): latency, arithmetic corners, stall and reset.
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int NG    = WIDTH / GROUP;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat: accepted at edge N, invisible after N+3, present after N+4.
    task automatic run_beat(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub,
                            input logic [15:0] esum, input logic ecout, input logic eovf);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (NG - 1) @(posedge clk);
        #1 chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        $display("beat %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 tag, ta, tb, tcin, tsub, sum, cout, ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_beat("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
        run_beat("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_beat("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
        run_beat("8000_p8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
        run_beat("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_beat("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_beat("8000_p8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif
        run_beat("5_m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_beat("cin_add", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        run_beat("sub_cin_ign", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Five back-to-back beats, then a two-cycle output stall with junk offered at the input.
        cin = 1'b0; sub = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            a = 16'(i); b = 16'(i); in_valid = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0; a = 16'h0F0F; b = 16'h0F0F;
        #1;
        chk("stall_first_valid", 32'(out_valid), 32'd1);
        chk("stall_first_sum", 32'(sum), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int s = 0; s < 2; s++) begin
            @(posedge clk);
            #1;
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_sum", 32'(sum), 32'd2);
            chk("stall_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            #1;
            chk("burst_valid", 32'(out_valid), 32'd1);
            chk("burst_sum", 32'(sum), 32'(2 * j));
            $display("burst result %0d sum=%0d out_valid=%0d", j, sum, out_valid);
            @(negedge clk);
        end
        #1 chk("burst_drained", 32'(out_valid), 32'd0);

        // Reset pulse with a held result and another beat in flight.
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h0300; b = 16'h0400;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && out_valid !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_sum", 32'(sum), 32'h0300);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset pulse out_valid=%0d sum=%h", out_valid, sum);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("no_stale_after_rst", 32'(seen), 32'd0);
        run_beat("fresh", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
